// File: rtl/lbist_controller.sv
// LBIST sequencer: for each seed, sends the seed to the LFSR and the hash count to the MISR,
// then compares the returned signature against its golden value. Reports one pass bit per round.
module lbist_controller #(
  parameter int SEED_BITS           = 32,
  parameter int SIGNATURE_BITS      = 32,
  parameter int NUM_SEEDS           = 8,
  parameter int MAX_OUTPUTS_TO_HASH = 32,
  parameter int LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH),
  parameter logic [NUM_SEEDS*SEED_BITS-1:0]      SEEDS             = '0,
  parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0] GOLDEN_SIGNATURES = '0
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      lbist_start_val,
  output logic                      lbist_start_rdy,

  output logic                      lbist_done_val,
  output logic [NUM_SEEDS-1:0]      lbist_done_msg,
  input  logic                      lbist_done_rdy,

  output logic                      lfsr_req_val,
  output logic [SEED_BITS-1:0]      lfsr_req_msg,
  input  logic                      lfsr_req_rdy,

  output logic                      misr_req_val,
  output logic [LBIST_MSG_BITS:0]   misr_req_msg,
  input  logic                      misr_req_rdy,

  input  logic                      misr_resp_val,
  input  logic [SIGNATURE_BITS-1:0] misr_resp_msg,
  output logic                      misr_resp_rdy
);

  localparam int IDX_BITS = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SEEDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t                  state;
  logic [IDX_BITS-1:0]     index;
  logic [IDX_BITS-1:0]     next_index;
  logic [SEED_BITS-1:0]    next_seed;
  logic [SIGNATURE_BITS-1:0] golden;
  logic                    lfsr_sent;
  logic                    misr_sent;
  logic [NUM_SEEDS-1:0]    result;

  assign next_index   = index + IDX_BITS'(1);
  assign next_seed    = SEEDS[next_index*SEED_BITS +: SEED_BITS];
  assign golden       = GOLDEN_SIGNATURES[index*SIGNATURE_BITS +: SIGNATURE_BITS];
  assign misr_req_msg = (LBIST_MSG_BITS+1)'(MAX_OUTPUTS_TO_HASH);
  assign lbist_done_msg = lbist_done_val ? result : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      index           <= '0;
      lfsr_sent       <= 1'b0;
      misr_sent       <= 1'b0;
      result          <= '0;
      lbist_start_rdy <= 1'b1;
      lfsr_req_val    <= 1'b0;
      misr_req_val    <= 1'b0;
      misr_resp_rdy   <= 1'b0;
      lbist_done_val  <= 1'b0;
      lfsr_req_msg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lbist_start_val) begin
            state           <= SEND;
            index           <= '0;
            result          <= '0;
            lbist_start_rdy <= 1'b0;
            lfsr_req_val    <= 1'b1;
            misr_req_val    <= 1'b1;
            lfsr_req_msg    <= SEEDS[0 +: SEED_BITS];
          end
        end
        SEND: begin
          if (lfsr_req_val && lfsr_req_rdy) begin
            lfsr_sent    <= 1'b1;
            lfsr_req_val <= 1'b0;
          end
          if (misr_req_val && misr_req_rdy) begin
            misr_sent    <= 1'b1;
            misr_req_val <= 1'b0;
          end
          // Both vals are already low here, so this never races the fire updates above.
          if (lfsr_sent && misr_sent) begin
            state         <= WAIT;
            lfsr_sent     <= 1'b0;
            misr_sent     <= 1'b0;
            misr_resp_rdy <= 1'b1;
          end
        end
        WAIT: begin
          if (misr_resp_val && misr_resp_rdy) begin
            result[index] <= (misr_resp_msg == golden);
            misr_resp_rdy <= 1'b0;
            if (index == LAST_IDX) begin
              state          <= DONE;
              lbist_done_val <= 1'b1;
            end else begin
              state        <= SEND;
              index        <= next_index;
              lfsr_req_val <= 1'b1;
              misr_req_val <= 1'b1;
              lfsr_req_msg <= next_seed;
            end
          end
        end
        DONE: begin
          if (lbist_done_rdy) begin
            state           <= IDLE;
            lbist_done_val  <= 1'b0;
            lbist_start_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
